// File: rtl/fp_add_pipelined.sv
// rtl/fp_add_pipelined.sv - fixed-latency IEEE-754 binary32 adder/subtractor, one op per clock
// Flush-to-zero on denormal inputs and results; round to nearest, ties to even.
module fp_add_pipelined #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        en,
  input  logic        sub,
  output logic [31:0] y
);

  typedef struct packed {
    logic        v;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t in_op;
  op_t core_op;

  assign in_op = {en, sub, a, b};

  // The first LAT-1 stages carry the captured operands; the arithmetic feeds the y register,
  // leaving retiming free to spread the logic across the stages.
  generate
    if (LAT == 1) begin : g_direct
      assign core_op = in_op;
    end else begin : g_dly
      op_t dly [LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT - 1; i++) dly[i].v <= 1'b0;
        end else begin
          dly[0] <= in_op;
          for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
        end
      end
      assign core_op = dly[LAT-2];
    end
  endgenerate

  logic              sa, sb, sl, ss;
  logic [7:0]        ea, eb, el, es, ediff;
  logic [22:0]       fa, fb;
  logic [23:0]       ml, ms;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, swap;
  logic [26:0]       sh, al;
  logic              sticky, found;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne, ne_r;
  logic              rnd;
  logic [23:0]       rf;
  logic [31:0]       res;

  always_comb begin
    sa     = core_op.a[31];
    ea     = core_op.a[30:23];
    fa     = core_op.a[22:0];
    sb     = core_op.b[31] ^ core_op.s;
    eb     = core_op.b[30:23];
    fb     = core_op.b[22:0];
    nan_a  = (ea == 8'hff) && (fa != 23'd0);
    nan_b  = (eb == 8'hff) && (fb != 23'd0);
    inf_a  = (ea == 8'hff) && (fa == 23'd0);
    inf_b  = (eb == 8'hff) && (fb == 23'd0);
    zero_a = (ea == 8'd0);
    zero_b = (eb == 8'd0);

    // {exp,frac} compares as magnitude for normal operands
    swap = core_op.b[30:0] > core_op.a[30:0];
    {sl, el, ml} = swap ? {sb, eb, 1'b1, fb} : {sa, ea, 1'b1, fa};
    {ss, es, ms} = swap ? {sa, ea, 1'b1, fa} : {sb, eb, 1'b1, fb};
    ediff = el - es;

    sh     = 27'd0;
    sticky = 1'b1;
    al     = 27'd1;
    if (ediff < 8'd27) begin
      sh     = {ms, 3'b000} >> ediff;
      sticky = |({ms, 3'b000} & ~({27{1'b1}} << ediff));
      al     = {sh[26:1], sh[0] | sticky};
    end

    sum = (sl == ss) ? ({1'b0, ml, 3'b000} + {1'b0, al})
                     : ({1'b0, ml, 3'b000} - {1'b0, al});

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end

    if (sum[27]) begin
      nm = {sum[27:2], sum[1] | sum[0]};
      ne = $signed({2'b00, el}) + 10'sd1;
    end else begin
      nm = sum[26:0] << lz;
      ne = $signed({2'b00, el}) - $signed({5'b00000, lz});
    end

    rnd  = nm[2] & (nm[1] | nm[0] | nm[3]);
    rf   = {1'b0, nm[25:3]} + 24'(rnd);
    ne_r = ne + $signed({9'd0, rf[23]});

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      res = 32'h7fc0_0000;
    end else if (inf_a) begin
      res = {sa, 8'hff, 23'd0};
    end else if (inf_b) begin
      res = {sb, 8'hff, 23'd0};
    end else if (zero_a && zero_b) begin
      res = {sa & sb, 31'd0};
    end else if (zero_a) begin
      res = {sb, core_op.b[30:0]};
    end else if (zero_b) begin
      res = {sa, core_op.a[30:0]};
    end else if (!nm[26]) begin
      res = 32'h0000_0000;
    end else if (ne_r >= 10'sd255) begin
      res = {sl, 8'hff, 23'd0};
    end else if (ne_r <= 10'sd0) begin
      res = {sl, 31'd0};
    end else begin
      res = {sl, ne_r[7:0], rf[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= 32'h0000_0000;
    end else if (core_op.v) begin
      y <= res;
    end
  end

endmodule

// File: tb/tb_fp_add_pipelined.sv
// tb/tb_fp_add_pipelined.sv - directed and random checks of fp_add_pipelined against a real-number model
module tb_fp_add_pipelined;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        en = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] y;

  int checks = 0;
  int errors = 0;
  logic [32:0] pend[$];
  logic [31:0] exp_y = 32'd0;

  fp_add_pipelined #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .sub(sub), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, want);
    end
  endtask

  function automatic real to_real(input logic s, input logic [7:0] e, input logic [22:0] m);
    return $bitstoreal({s, 11'(e) + 11'd896, m, 29'd0});
  endfunction

  // Exact double sum rounded once to binary32 (RNE), with overflow to Inf and flush-to-zero
  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [22:0] keep;
    logic [28:0] rem;
    logic [23:0] mant;
    int          e;
    d    = $realtobits(r);
    e    = int'(d[62:52]) - 896;
    keep = d[51:29];
    rem  = d[28:0];
    mant = {1'b0, keep};
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) mant = mant + 24'd1;
    if (mant[23]) e = e + 1;
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] z, input logic s);
    logic sx, sz, nx, nz, ix, iz, zx, zz;
    real  r;
    sx = x[31];
    sz = z[31] ^ s;
    nx = (x[30:23] == 8'hff) && (x[22:0] != 0);
    nz = (z[30:23] == 8'hff) && (z[22:0] != 0);
    ix = (x[30:23] == 8'hff) && (x[22:0] == 0);
    iz = (z[30:23] == 8'hff) && (z[22:0] == 0);
    zx = (x[30:23] == 8'd0);
    zz = (z[30:23] == 8'd0);
    if (nx || nz) return 32'h7fc0_0000;
    if (ix && iz) return (sx != sz) ? 32'h7fc0_0000 : {sx, 8'hff, 23'd0};
    if (ix) return {sx, 8'hff, 23'd0};
    if (iz) return {sz, 8'hff, 23'd0};
    if (zx && zz) return {sx & sz, 31'd0};
    r = (zx ? 0.0 : to_real(sx, x[30:23], x[22:0])) + (zz ? 0.0 : to_real(sz, z[30:23], z[22:0]));
    if (r == 0.0) return 32'h0000_0000;
    return to_f32(r);
  endfunction

  // One clock: drive inputs, then after the edge advance the expected-y model and compare
  task automatic tick(input string tag, input logic r, input logic e, input logic [31:0] xa,
                      input logic [31:0] xb, input logic s, input logic [31:0] want);
    logic [32:0] head;
    @(negedge clk);
    rst = r; en = e; a = xa; b = xb; sub = s;
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
      for (int i = 0; i < LAT - 1; i++) pend.push_back(33'd0);
      exp_y = 32'd0;
    end else begin
      pend.push_back({e, want});
      if (pend.size() > LAT - 1) begin
        head = pend.pop_front();
        if (head[32]) exp_y = head[31:0];
      end
    end
    check(tag, y, exp_y);
  endtask

  task automatic op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                    input logic s, input logic [31:0] want);
    tick(tag, 1'b0, 1'b1, xa, xb, s, want);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          issued, e1, e2;

    tick("reset", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick("reset", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    check("reset_y", y, 32'h0000_0000);

    op("add_basic", 32'h3f80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    op("sub_basic", 32'h3f80_0000, 32'h4000_0000, 1'b1, 32'hbf80_0000);
    op("cancel", 32'h3f80_0000, 32'h3f80_0000, 1'b1, 32'h0000_0000);
    op("neg_zeros", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
    op("mixed_zeros", 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000);
    op("tie_even", 32'h3f80_0000, 32'h3380_0000, 1'b0, 32'h3f80_0000);
    op("tie_up", 32'h3f80_0001, 32'h3380_0000, 1'b0, 32'h3f80_0002);
    op("overflow", 32'h7f7f_ffff, 32'h7f7f_ffff, 1'b0, 32'h7f80_0000);
    op("inf_minus_inf", 32'h7f80_0000, 32'h7f80_0000, 1'b1, 32'h7fc0_0000);
    op("nan_in", 32'h7fc0_0001, 32'h3f80_0000, 1'b0, 32'h7fc0_0000);
    op("ninf_plus_fin", 32'hff80_0000, 32'h42c8_0000, 1'b0, 32'hff80_0000);
    op("denorm_ftz", 32'h0000_0001, 32'h3f80_0000, 1'b0, 32'h3f80_0000);
    op("underflow", 32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000);
    idle("drain", LAT + 1);

    op("pipe_1", 32'h3f80_0000, 32'h3f80_0000, 1'b0, 32'h4000_0000);
    op("pipe_2", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
    op("pipe_3", 32'h4040_0000, 32'h4040_0000, 1'b0, 32'h40c0_0000);
    idle("pipe_hold", 5);
    check("pipe_final", y, 32'h40c0_0000);

    op("flush_op1", 32'h3f80_0000, 32'h3f80_0000, 1'b0, 32'h4000_0000);
    op("flush_op2", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
    tick("flush_rst", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    idle("flush_quiet", LAT + 3);
    check("flush_final", y, 32'h0000_0000);

    issued = 0;
    while (issued < 10000) begin
      if ($urandom_range(0, 4) == 0) begin
        idle("rand_idle", 1);
      end else begin
        e1 = $urandom_range(1, 254);
        e2 = ($urandom_range(0, 1) == 1) ? e1 + $urandom_range(0, 60) - 30 : $urandom_range(1, 254);
        if (e2 < 1) e2 = 1;
        if (e2 > 254) e2 = 254;
        ra = {1'($urandom), 8'(e1), 23'($urandom)};
        rb = {1'($urandom), 8'(e2), 23'($urandom)};
        if ($urandom_range(0, 15) == 0) rb[30:0] = ra[30:0];
        rs = 1'($urandom);
        op("rand", ra, rb, rs, ref_add(ra, rb, rs));
        issued++;
      end
    end
    idle("rand_drain", LAT + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
